// File: rtl/booth_iter_mult_pkg.sv
// Shared types and helpers for the iterative Booth multiplier: FSM states,
// recode operation selects and the step-count function.
package booth_iter_mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    // Operation applied to the accumulator in one Booth step.
    typedef enum logic [2:0] {
        ZERO = 3'd0,
        PM   = 3'd1,
        P2M  = 3'd2,
        NM   = 3'd3,
        N2M  = 3'd4
    } booth_op_t;

    // Number of RUN cycles: one per bit (radix-2) or one per bit pair (radix-4).
    function automatic int booth_steps(input int width, input int radix4);
        return (radix4 != 0) ? (width + 1) / 2 : width;
    endfunction

endpackage

// File: rtl/booth_recode.sv
// Booth digit recoder: maps the low multiplier bits plus the previously
// shifted-out bit to the accumulator operation for one step.
module booth_recode
    import booth_iter_mult_pkg::*;
#(
    parameter int RADIX4 = 0
) (
    input  logic [RADIX4:0] q_lsbs,
    input  logic            q_m1,
    output booth_op_t       op
);

    generate
        if (RADIX4 != 0) begin : g_radix4
            always_comb begin
                op = ZERO;
                case ({q_lsbs, q_m1})
                    3'b001, 3'b010: op = PM;
                    3'b011:         op = P2M;
                    3'b100:         op = N2M;
                    3'b101, 3'b110: op = NM;
                    default:        op = ZERO;
                endcase
            end
        end else begin : g_radix2
            always_comb begin
                op = ZERO;
                case ({q_lsbs, q_m1})
                    2'b01:   op = PM;
                    2'b10:   op = NM;
                    default: op = ZERO;
                endcase
            end
        end
    endgenerate

endmodule

// File: rtl/booth_iter_mult.sv
// Iterative signed Booth multiplier (radix-2 or radix-4), one recode step per
// clock, with a sideband tag carried from accept to result.
module booth_iter_mult
    import booth_iter_mult_pkg::*;
#(
    parameter int WIDTH  = 25,
    parameter int RADIX4 = 0,
    parameter int TAG_W  = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [TAG_W-1:0]     tag_in,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [TAG_W-1:0]     tag_out,
    output logic [1:0]           state_dbg
);

    // Handshake: start is taken only when busy is low (IDLE); busy stays high
    // through RUN and FINISH; done pulses one cycle with product/tag_out valid,
    // and those outputs hold until the next completed operation.

    localparam int N  = booth_steps(WIDTH, RADIX4);
    localparam int AW = (RADIX4 != 0) ? WIDTH + 2 : WIDTH + 1;
    localparam int QW = ((RADIX4 != 0) && (WIDTH % 2 == 1)) ? WIDTH + 1 : WIDTH;
    localparam int SH = (RADIX4 != 0) ? 2 : 1;
    localparam int RW = AW + QW + 1;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

    state_t state, state_next;

    logic [WIDTH-1:0]  m_reg;
    logic [TAG_W-1:0]  tag_reg;
    logic [AW-1:0]     a_reg;
    logic [QW-1:0]     q_reg;
    logic              q_m1;
    logic [CW-1:0]     step_cnt;

    logic signed [QW-1:0] q_load;
    logic [AW-1:0]     m_ext, m2_ext, sel, sum;
    logic              neg;
    logic [RW-1:0]     shifted;
    booth_op_t         op;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b1;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_next = ST_RUN;
            end
            ST_RUN:    if (step_cnt == LAST_STEP) state_next = ST_FINISH;
            ST_FINISH: state_next = ST_IDLE;
            default: begin
                busy       = 1'b0;
                state_next = ST_IDLE;
            end
        endcase
    end

    assign state_dbg = state;

    booth_recode #(.RADIX4(RADIX4)) u_recode (
        .q_lsbs (q_reg[RADIX4:0]),
        .q_m1   (q_m1),
        .op     (op)
    );

    // Odd radix-4 widths need one extra sign bit so the last pair is complete.
    assign q_load = $signed(multiplier);
    assign m_ext  = {{(AW - WIDTH){m_reg[WIDTH-1]}}, m_reg};
    assign m2_ext = {m_ext[AW-2:0], 1'b0};

    always_comb begin
        sel = '0;
        neg = 1'b0;
        case (op)
            PM:      sel = m_ext;
            P2M:     sel = m2_ext;
            NM:  begin sel = m_ext;  neg = 1'b1; end
            N2M: begin sel = m2_ext; neg = 1'b1; end
            default: sel = '0;
        endcase
    end

    // Negation is the inverted addend plus a carry-in of one.
    assign sum     = a_reg + (neg ? ~sel : sel) + AW'(neg);
    assign shifted = RW'($signed({sum, q_reg, q_m1}) >>> SH);

    always_ff @(posedge clk) begin
        if (reset) begin
            m_reg    <= '0;
            tag_reg  <= '0;
            a_reg    <= '0;
            q_reg    <= '0;
            q_m1     <= 1'b0;
            step_cnt <= '0;
            product  <= '0;
            tag_out  <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        m_reg    <= multiplicand;
                        tag_reg  <= tag_in;
                        a_reg    <= '0;
                        q_reg    <= q_load;
                        q_m1     <= 1'b0;
                        step_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    a_reg    <= shifted[RW-1 -: AW];
                    q_reg    <= shifted[QW:1];
                    q_m1     <= shifted[0];
                    step_cnt <= step_cnt + CW'(1);
                end
                ST_FINISH: begin
                    product <= {a_reg[2*WIDTH-QW-1:0], q_reg};
                    tag_out <= tag_reg;
                    done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_iter_mult.sv
// Bench for booth_iter_mult: six instances (WIDTH 8/7/25 x radix-2/4) checked
// against plain signed multiplication and the documented cycle timing.
module tb_booth_iter_mult;

    localparam int NG = 6;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        start_v [NG];
    logic [24:0] mc_v    [NG];
    logic [24:0] mq_v    [NG];
    logic [9:0]  tag_v   [NG];
    logic        busy_v  [NG];
    logic        done_v  [NG];
    logic signed [63:0] prod_v [NG];
    logic [9:0]  tagout_v [NG];
    logic [1:0]  state_v [NG];

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < NG; g++) begin : g_dut
        localparam int W = (g < 2) ? 8 : ((g < 4) ? 7 : 25);
        localparam int R = g % 2;
        logic [2*W-1:0] prod_w;
        booth_iter_mult #(.WIDTH(W), .RADIX4(R), .TAG_W(10)) u_dut (
            .clk          (clk),
            .reset        (reset),
            .start        (start_v[g]),
            .multiplicand (mc_v[g][W-1:0]),
            .multiplier   (mq_v[g][W-1:0]),
            .tag_in       (tag_v[g]),
            .busy         (busy_v[g]),
            .done         (done_v[g]),
            .product      (prod_w),
            .tag_out      (tagout_v[g]),
            .state_dbg    (state_v[g])
        );
        assign prod_v[g] = 64'($signed(prod_w));
    end

    function automatic int cfg_w(input int g);
        return (g < 2) ? 8 : ((g < 4) ? 7 : 25);
    endfunction

    function automatic int cfg_n(input int g);
        int w;
        w = cfg_w(g);
        return (g % 2 == 1) ? (w + 1) / 2 : w;
    endfunction

    function automatic longint sx(input logic [24:0] v, input int w);
        longint t;
        t = longint'({39'b0, v});
        t = t <<< (64 - w);
        return t >>> (64 - w);
    endfunction

    function automatic longint ref_prod(input logic [24:0] m, input logic [24:0] q, input int w);
        return sx(m, w) * sx(q, w);
    endfunction

    function automatic logic [24:0] rand_op(input int w);
        logic [24:0] mask;
        mask = 25'((64'd1 << w) - 64'd1);
        case ($urandom_range(0, 9))
            0:       return 25'(64'd1 << (w - 1));
            1:       return 25'((64'd1 << (w - 1)) - 64'd1);
            2:       return mask;
            3:       return 25'd0;
            default: return 25'($urandom) & mask;
        endcase
    endfunction

    // One operation on instance g; lat is the edge count from accept to the
    // edge that sees done high.
    task automatic run_op(input int g, input logic [24:0] m, input logic [24:0] q,
                          input logic [9:0] t, output longint p, output logic [9:0] to,
                          output int lat, output bit ok);
        @(negedge clk);
        mc_v[g] = m; mq_v[g] = q; tag_v[g] = t; start_v[g] = 1'b1;
        @(negedge clk);
        start_v[g] = 1'b0;
        ok = 1'b0; lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done_v[g]) begin
                ok = 1'b1; lat = k + 1;
                break;
            end
        end
        p = prod_v[g]; to = tagout_v[g];
    endtask

    task automatic test_reset;
        reset = 1'b1;
        for (int g = 0; g < NG; g++) begin
            start_v[g] = 1'b1; mc_v[g] = 25'h5; mq_v[g] = 25'h3; tag_v[g] = 10'h3ff;
        end
        repeat (3) @(negedge clk);
        for (int g = 0; g < NG; g++) begin
            checks++;
            if (busy_v[g] !== 1'b0 || done_v[g] !== 1'b0) begin
                errors++; $display("FAIL reset_ctrl g=%0d busy=%b done=%b required 0/0", g, busy_v[g], done_v[g]);
            end
            checks++;
            if (prod_v[g] !== 64'sd0 || tagout_v[g] !== 10'h0) begin
                errors++; $display("FAIL reset_data g=%0d product=%0d tag=%h required 0/0", g, prod_v[g], tagout_v[g]);
            end
            start_v[g] = 1'b0;
        end
        reset = 1'b0;
    endtask

    task automatic test_directed;
        longint p; logic [9:0] to; int lat; bit ok;
        run_op(0, 25'h07, 25'hfd, 10'h012, p, to, lat, ok);
        checks++;
        if (!ok || p !== -64'sd21 || lat != 10) begin
            errors++; $display("FAIL r2_w8_7x-3 ok=%0d product=%0d lat=%0d required -21 lat 10", ok, p, lat);
        end
        run_op(1, 25'h80, 25'h80, 10'h021, p, to, lat, ok);
        checks++;
        if (!ok || p !== 64'sd16384 || lat != 6) begin
            errors++; $display("FAIL r4_w8_min_sq ok=%0d product=%0d lat=%0d required 16384 lat 6", ok, p, lat);
        end
        for (int g = 4; g < 6; g++) begin
            run_op(g, 25'h0800000, 25'h0C00000, 10'h155, p, to, lat, ok);
            checks++;
            if (!ok || p !== 64'sh6000_0000_0000 || to !== 10'h155) begin
                errors++; $display("FAIL w25_big g=%0d product=%h tag=%h required 600000000000/155", g, p, to);
            end
            checks++;
            if (lat != cfg_n(g) + 2) begin
                errors++; $display("FAIL w25_latency g=%0d lat=%0d required %0d", g, lat, cfg_n(g) + 2);
            end
        end
    endtask

    task automatic test_start_held;
        longint exp_q[$];
        logic [24:0] m, q;
        longint e;
        int period, dones, last_done;
        period = cfg_n(0) + 2;
        dones = 0; last_done = -1;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            if (done_v[0]) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL held_extra_done cycle=%0d product=%0d required no done", c, prod_v[0]);
                end else begin
                    e = exp_q.pop_front();
                    if (prod_v[0] !== e) begin
                        errors++; $display("FAIL held_product cycle=%0d product=%0d required %0d", c, prod_v[0], e);
                    end
                end
                if (last_done >= 0) begin
                    checks++;
                    if (c - last_done != period) begin
                        errors++; $display("FAIL held_spacing spacing=%0d required %0d", c - last_done, period);
                    end
                end
                last_done = c; dones++;
            end
            if (c < 30) begin
                m = rand_op(8); q = rand_op(8);
                mc_v[0] = m; mq_v[0] = q; start_v[0] = 1'b1;
                if (c % period == 0) exp_q.push_back(ref_prod(m, q, 8));
            end else begin
                start_v[0] = 1'b0;
            end
        end
        checks++;
        if (dones != 3 || exp_q.size() != 0) begin
            errors++; $display("FAIL held_count dones=%0d pending=%0d required 3/0", dones, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_run;
        longint p; logic [9:0] to; int lat; bit ok; int seen;
        @(negedge clk);
        mc_v[0] = 25'h35; mq_v[0] = 25'h4b; tag_v[0] = 10'h0aa; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (done_v[0]) seen++;
        end
        checks++;
        if (seen != 0 || prod_v[0] !== 64'sd0 || busy_v[0] !== 1'b0) begin
            errors++; $display("FAIL abort dones=%0d product=%0d busy=%b required 0/0/0", seen, prod_v[0], busy_v[0]);
        end
        run_op(0, 25'h35, 25'h4b, 10'h0aa, p, to, lat, ok);
        checks++;
        if (!ok || p !== ref_prod(25'h35, 25'h4b, 8) || to !== 10'h0aa) begin
            errors++; $display("FAIL after_abort product=%0d tag=%h required %0d/0aa", p, to, ref_prod(25'h35, 25'h4b, 8));
        end
    endtask

    task automatic test_random;
        logic [24:0] m, q;
        longint exp_p [NG];
        logic [9:0] exp_t [NG];
        bit got [NG];
        bit all_got;
        for (int r = 0; r < 1667; r++) begin
            @(negedge clk);
            for (int g = 0; g < NG; g++) begin
                m = rand_op(cfg_w(g)); q = rand_op(cfg_w(g));
                mc_v[g] = m; mq_v[g] = q; tag_v[g] = 10'($urandom);
                exp_p[g] = ref_prod(m, q, cfg_w(g)); exp_t[g] = tag_v[g];
                start_v[g] = 1'b1; got[g] = 1'b0;
            end
            @(negedge clk);
            for (int g = 0; g < NG; g++) start_v[g] = 1'b0;
            for (int k = 1; k <= 40; k++) begin
                @(negedge clk);
                all_got = 1'b1;
                for (int g = 0; g < NG; g++) begin
                    if (!got[g] && done_v[g]) begin
                        got[g] = 1'b1;
                        checks++;
                        if (prod_v[g] !== exp_p[g] || tagout_v[g] !== exp_t[g]) begin
                            errors++; $display("FAIL random g=%0d product=%0d tag=%h required %0d/%h", g, prod_v[g], tagout_v[g], exp_p[g], exp_t[g]);
                        end
                        checks++;
                        if (k + 1 != cfg_n(g) + 2) begin
                            errors++; $display("FAIL random_latency g=%0d lat=%0d required %0d", g, k + 1, cfg_n(g) + 2);
                        end
                    end
                    all_got &= got[g];
                end
                if (all_got) break;
            end
            for (int g = 0; g < NG; g++) begin
                if (!got[g]) begin
                    checks++; errors++;
                    $display("FAIL random_timeout g=%0d round=%0d done=0 required 1", g, r);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int g = 0; g < NG; g++) begin
            start_v[g] = 1'b0; mc_v[g] = '0; mq_v[g] = '0; tag_v[g] = '0;
        end
        test_reset;
        test_directed;
        test_start_held;
        test_reset_mid_run;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
